// File: rtl/midi_uart_tx.sv
// MIDI OUT transmitter: 31.25 kbaud 8N1, LSB first, with a small byte FIFO
// so the processor can burst a whole message without polling between bytes.
module midi_uart_tx #(
    parameter int CLK_DIV = 77,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       write,
    output logic       txd,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    input  logic       overflow_clr,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic [3:0] CS
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        D0    = 4'd2,
        D1    = 4'd3,
        D2    = 4'd4,
        D3    = 4'd5,
        D4    = 4'd6,
        D5    = 4'd7,
        D6    = 4'd8,
        D7    = 4'd9,
        STOP  = 4'd10
    } state_t;

    // Handshake: write is a one-cycle strobe with no ready; the processor
    // checks full first, and a write while full is dropped and flagged.
    logic [DIV_W-1:0]   div_q, div_d;
    logic               tick;
    logic [3:0]         tcnt_q, tcnt_d;
    logic [3:0]         state_q;
    state_t             state_d, nxt;
    logic [7:0]         shreg_q, shreg_d;
    logic               txd_q, txd_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full_q, full_d, empty_q, empty_d, busy_q, busy_d;
    logic               done_q, done_d, overflow_q, overflow_d;
    logic               interrupt_q, interrupt_d;
    logic               wr_ok, pop;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d   = tick ? '0 : div_q + DIV_ONE;
        state_d = state_t'(state_q);
        nxt     = state_t'(state_q + 4'd1);
        tcnt_d  = tcnt_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rptr_q];
                    txd_d   = 1'b0;
                    tcnt_d  = 4'd0;
                    state_d = START;
                end
            end
            START, D0, D1, D2, D3, D4, D5, D6, D7: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        state_d = nxt;
                        if (state_q == D7) begin
                            txd_d = 1'b1;
                        end else begin
                            txd_d   = shreg_q[0];
                            shreg_d = {1'b0, shreg_q[7:1]};
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        done_d = 1'b1;
                        // Queued byte starts straight away: no idle gap.
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shreg_d = mem_q[rptr_q];
                            txd_d   = 1'b0;
                            state_d = START;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                tcnt_d  = 4'd0;
            end
        endcase

        // Full is judged on the pre-cycle count, so a same-cycle pop never
        // makes room for a write that arrived while full.
        wr_ok  = write && (count_q != CNT_FULL);
        mem_d  = mem_q;
        wptr_d = wptr_q;
        if (wr_ok) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + PTR_ONE;
        end
        rptr_d  = pop ? rptr_q + PTR_ONE : rptr_q;
        count_d = count_q;
        if (wr_ok && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_ok && pop) begin
            count_d = count_q - CNT_ONE;
        end

        full_d      = (count_d == CNT_FULL);
        empty_d     = (count_d == '0);
        busy_d      = (state_d != IDLE);
        overflow_d  = (overflow_q && !overflow_clr) || (write && !wr_ok);
        interrupt_d = (interrupt_q && !interrupt_ack) || done_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            tcnt_q      <= 4'd0;
            state_q     <= IDLE;
            shreg_q     <= 8'h00;
            txd_q       <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            interrupt_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            tcnt_q      <= tcnt_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            txd_q       <= txd_d;
            mem_q       <= mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign txd       = txd_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign interrupt = interrupt_q;
    assign CS        = state_q;

endmodule

// File: doc/midi_uart_tx.md
# midi_uart_tx

MIDI-rate UART transmitter (31.25 kbaud, 8N1, LSB first) with a small input FIFO, so a PicoBlaze can burst a complete MIDI message (up to FIFO_DEPTH bytes) without polling between bytes. It is the transmit-side counterpart of the MIDI receiver. It generates its own 16x baud tick from the system clock and drives the MIDI OUT line. It also provides status flags and a sticky interrupt flag for the processor port interface.

## Interface

Parameters:
- CLK_DIV, 77 — system clocks per 16x baud tick; 38.4 MHz / 77 ≈ 498.7 kHz ≈ 16 × 31.17 kbaud (−0.26 % error); use 100 for 50 MHz.
- FIFO_AW, 2 — FIFO address width; depth = 2**FIFO_AW = 4.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high; clears everything.
- din  in  8  byte to transmit; sampled when write=1.
- write  in  1  one-cycle write strobe.
- txd  out  1  serial output; idles high; registered.
- full  out  1  FIFO holds 2**FIFO_AW bytes.
- empty  out  1  FIFO holds 0 bytes.
- busy  out  1  a frame is in progress (state ≠ IDLE).
- done  out  1  one-clk pulse at the end of each stop bit.
- overflow  out  1  sticky; a write was attempted while full.
- overflow_clr  in  1  synchronous clear of overflow.
- interrupt  out  1  sticky; set by done.
- interrupt_ack  in  1  synchronous clear of interrupt.
- CS  out  4  current FSM state, for debug.

## Operation

- Baud divider: a free-running counter runs 0..CLK_DIV−1. The tick pulses for one clk when the counter wraps. The divider is never resynchronised.
- FIFO writes:
  - A write is accepted iff the pre-cycle count < depth. The byte is stored and count increments.
  - A write while full is dropped, sets overflow, and leaves the FIFO unchanged.
  - Pointers wrap modulo depth. count is FIFO_AW+1 bits wide.
- FSM states: IDLE=0, START=1, D0..D7=2..9, STOP=10. Codes 11–15 go to IDLE.
  - IDLE: on a tick with pre-cycle count > 0, pop the head into the shift register, drive txd=0, and go to START. The tick counter is reset to 0.
  - Each of START and D0–D7 lasts exactly 16 ticks. On the 16th tick (tick counter 15→0), advance to the next state.
    - Entering Dn drives txd = shreg[0], then shreg >>= 1.
    - Entering STOP drives txd = 1.
  - STOP: after 16 ticks, pulse done for one clk.
    - If count > 0 at that cycle, pop immediately, drive txd=0, and go to START. Back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- Simultaneous events:
  - Write and pop in the same clk: count is unchanged. If the FIFO was full, the write is still rejected (pre-cycle full).
  - A write to an empty FIFO during an IDLE tick cycle is not popped until the next tick.
  - done and interrupt_ack in the same clk: set wins, so interrupt stays 1.
  - overflow set and overflow_clr in the same clk: set wins.
- Reset mid-frame:
  - txd returns to 1 immediately (async). The FIFO is flushed and the frame is aborted.
  - No done pulse is generated.

## Timing

- Reset values: txd=1, full=0, empty=1, busy=0, done=0, overflow=0, interrupt=0, CS=0. Divider, tick counter, shift register and pointers are all 0.
- Flags full, empty, busy and CS are registered. They reflect state one clk after the causing edge.
- Latency:
  - First start edge follows the write by 1 clk to CLK_DIV+1 clk, depending on divider phase.
  - Each bit lasts 16·CLK_DIV clk = 1232 clk at default.
  - A frame lasts 160 ticks = 12320 clk.
- done is asserted in the same clk that txd leaves STOP. interrupt rises on the following clk.
- Sustained throughput is one byte per 160 ticks while the FIFO is non-empty.

## Test plan

- Single byte: write 0x90 from idle. txd must be 0 (start), then bits 0,0,0,0,1,0,0,1, then 1 (stop), each held 1232 clk. Expect exactly one done pulse. interrupt=1 until interrupt_ack, and empty=1 afterwards.
- Back-to-back: write 0x90, 0x3C, 0x64 on consecutive clks. Expect three contiguous frames with no idle high between the stop and the next start. Expect 3 done pulses, busy held high for 36960 clk, and full never asserted.
- Overflow: 5 writes (0x01..0x05) within 5 clks while idle.
  - One byte is popped only if a tick falls inside the burst; force the divider phase so none does.
  - full=1 after the 4th write. The 5th write is dropped and sets overflow=1.
  - Exactly 0x01..0x04 are transmitted. overflow_clr then drops overflow.
- Reset mid-frame: assert reset during D3 of 0xFF with 2 bytes queued. txd=1 and empty=1 immediately, no done pulse, and no further frames after release.
- Interrupt/ack collision: assert interrupt_ack in the same clk as done. interrupt stays 1. A subsequent ack alone clears it.
- Divider/config: with CLK_DIV=100, measure the start-bit width = 1600 clk ±0. Also verify an illegal CS injection (via force of 4'hB) recovers to IDLE within 1 clk.
